// File: rtl/adc_pulse_synth.sv
// adc_pulse_synth: synthetic ADC source playing a three-pulse sequence on channels a/b/c with a sample counter on d.
// Optional PULSE_SYNTH_NOISE_EN adds 16-bit LFSR noise (-8..+7) to every a/b/c sample.
module adc_pulse_synth #(
  parameter int ADC_DATA_WIDTH = 16,
  parameter int CNT_WIDTH      = 24
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        start,
  input  logic [ADC_DATA_WIDTH-1:0]   baseline,
  input  logic [3*ADC_DATA_WIDTH-1:0] amplitude_arr,
  input  logic [ADC_DATA_WIDTH-2:0]   slope,
  input  logic [3*CNT_WIDTH-1:0]      gap_arr,
  input  logic [CNT_WIDTH-1:0]        width,
  output logic [2*ADC_DATA_WIDTH-1:0] adc_data_a,
  output logic [2*ADC_DATA_WIDTH-1:0] adc_data_b,
  output logic [2*ADC_DATA_WIDTH-1:0] adc_data_c,
  output logic [2*ADC_DATA_WIDTH-1:0] adc_data_d,
  output logic                        adc_enable_a,
  output logic                        adc_enable_b,
  output logic                        adc_enable_c,
  output logic                        adc_enable_d,
  output logic                        adc_valid_a,
  output logic                        adc_valid_b,
  output logic                        adc_valid_c,
  output logic                        adc_valid_d,
  output logic                        busy,
  output logic                        done
);
  localparam int W = ADC_DATA_WIDTH;
  localparam int C = CNT_WIDTH;
  localparam logic [C-1:0] TIMER_ONE = {{(C-1){1'b0}}, 1'b1};
  localparam logic [W-1:0] CNT_ONE   = {{(W-1){1'b0}}, 1'b1};
  localparam logic [W-1:0] CNT_TWO   = {{(W-2){1'b0}}, 2'b10};
  localparam logic signed [W-1:0] SMAX = {1'b0, {(W-1){1'b1}}};
  localparam logic signed [W-1:0] SMIN = {1'b1, {(W-1){1'b0}}};

  typedef enum logic [2:0] {IDLE, GAP, RISE, HOLD, FALL, DONE} state_t;

  function automatic logic signed [W-1:0] sat(input logic signed [W:0] x);
    if (x[W] != x[W-1]) return x[W] ? SMIN : SMAX;
    return x[W-1:0];
  endfunction

  // One ramp sample: move by stp toward 'to' and never overshoot it; a zero step jumps straight there.
  function automatic logic signed [W-1:0] step_to(input logic signed [W-1:0] from,
                                                  input logic signed [W-1:0] to,
                                                  input logic [W-2:0] stp);
    logic signed [W-1:0] s;
    if (stp == '0) return to;
    if (to >= from) begin
      s = sat($signed({from[W-1], from}) + $signed({2'b00, stp}));
      return (s > to) ? to : s;
    end
    s = sat($signed({from[W-1], from}) - $signed({2'b00, stp}));
    return (s < to) ? to : s;
  endfunction

  function automatic logic [W-1:0] add_noise(input logic signed [W-1:0] x, input logic [3:0] n);
    return sat($signed({x[W-1], x}) + $signed({{(W-3){n[3]}}, n}));
  endfunction

  function automatic logic [C-1:0] max1(input logic [C-1:0] x);
    return (x == '0) ? TIMER_ONE : x;
  endfunction

  state_t state, state_n;
  logic [1:0] k, k_n;
  logic [C-1:0] timer, timer_n, gap_next;
  logic signed [W-1:0] level, level_n, base_out, amp_k, tgt, r0, r1, s0_n, s1_n;
  logic signed [W-1:0] base_s;
  logic [3*W-1:0] amp_s;
  logic [W-2:0] slope_s;
  logic [2*C-1:0] gap_s;
  logic [C-1:0] width_s;
  logic [W-1:0] cnt, cnt_n;
  logic load;
  logic [3:0] noise0, noise1;
  logic [2*W-1:0] data_a_n, data_b_n, data_c_n, data_d_n, pulse_word;

`ifdef PULSE_SYNTH_NOISE_EN
  function automatic logic [15:0] lfsr_step(input logic [15:0] l);
    return {l[0] ^ l[2] ^ l[3] ^ l[5], l[15:1]};
  endfunction

  logic [15:0] lfsr, lfsr_mid, lfsr_nxt;
  assign lfsr_mid = lfsr_step(lfsr);
  assign lfsr_nxt = lfsr_step(lfsr_mid);
  assign noise0   = lfsr_mid[3:0];
  assign noise1   = lfsr_nxt[3:0];

  // The LFSR free-runs two steps per clock: the earlier sample takes the first step's bits.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) lfsr <= 16'hACE1;
    else     lfsr <= lfsr_nxt;
  end
`else
  assign noise0 = 4'd0;
  assign noise1 = 4'd0;
`endif

  always_comb begin
    amp_k    = amp_s[W-1:0];
    gap_next = gap_s[C-1:0];
    case (k)
      2'd1: begin
        amp_k    = amp_s[2*W-1:W];
        gap_next = gap_s[2*C-1:C];
      end
      2'd2: amp_k = amp_s[3*W-1:2*W];
      default: ;
    endcase
  end

  // level always holds the later, pre-noise sample of the current clock, so ramps resume from it.
  assign tgt = (state == GAP || state == RISE) ? amp_k : base_s;
  assign r0  = step_to(level, tgt, slope_s);
  assign r1  = step_to(r0, tgt, slope_s);

  // Next-state logic also produces the samples that will be shown during the next state's clock.
  always_comb begin
    state_n  = state;
    k_n      = k;
    timer_n  = timer;
    level_n  = level;
    load     = 1'b0;
    base_out = (state == IDLE || state == DONE) ? $signed(baseline) : base_s;
    s0_n     = base_out;
    s1_n     = base_out;
    unique case (state)
      IDLE: if (start) begin
        load    = 1'b1;
        state_n = GAP;
        k_n     = 2'd0;
        timer_n = max1(gap_arr[C-1:0]);
        level_n = base_out;
      end
      GAP: if (timer <= TIMER_ONE) begin
        state_n = RISE;
        s0_n    = r0;
        s1_n    = r1;
        level_n = r1;
      end else timer_n = timer - TIMER_ONE;
      RISE: if (level == amp_k) begin
        state_n = HOLD;
        timer_n = max1(width_s);
        s0_n    = amp_k;
        s1_n    = amp_k;
        level_n = amp_k;
      end else begin
        s0_n    = r0;
        s1_n    = r1;
        level_n = r1;
      end
      HOLD: if (timer <= TIMER_ONE) begin
        state_n = FALL;
        s0_n    = r0;
        s1_n    = r1;
        level_n = r1;
      end else begin
        timer_n = timer - TIMER_ONE;
        s0_n    = amp_k;
        s1_n    = amp_k;
      end
      FALL: if (level == base_s) begin
        if (k == 2'd2) state_n = DONE;
        else begin
          state_n = GAP;
          k_n     = k + 2'd1;
          timer_n = max1(gap_next);
        end
      end else begin
        s0_n    = r0;
        s1_n    = r1;
        level_n = r1;
      end
      DONE: state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_comb begin
    data_a_n   = {add_noise(base_out, noise1), add_noise(base_out, noise0)};
    data_b_n   = data_a_n;
    data_c_n   = data_a_n;
    pulse_word = {add_noise(s1_n, noise1), add_noise(s0_n, noise0)};
    if (state_n != IDLE) begin
      case (k_n)
        2'd0: data_a_n = pulse_word;
        2'd1: data_b_n = pulse_word;
        2'd2: data_c_n = pulse_word;
        default: ;
      endcase
    end
    cnt_n = load ? '0 : (state != IDLE) ? cnt + CNT_TWO : cnt;
    data_d_n = (state_n != IDLE) ? {cnt_n + CNT_ONE, cnt_n} : adc_data_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      k          <= '0;
      timer      <= '0;
      level      <= '0;
      base_s     <= '0;
      amp_s      <= '0;
      slope_s    <= '0;
      gap_s      <= '0;
      width_s    <= '0;
      cnt        <= '0;
      adc_data_a <= '0;
      adc_data_b <= '0;
      adc_data_c <= '0;
      adc_data_d <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      state      <= state_n;
      k          <= k_n;
      timer      <= timer_n;
      level      <= level_n;
      cnt        <= cnt_n;
      adc_data_a <= data_a_n;
      adc_data_b <= data_b_n;
      adc_data_c <= data_c_n;
      adc_data_d <= data_d_n;
      busy       <= (state_n != IDLE);
      done       <= (state_n == DONE);
      if (load) begin
        base_s  <= $signed(baseline);
        amp_s   <= amplitude_arr;
        slope_s <= slope;
        gap_s   <= gap_arr[3*C-1:C];
        width_s <= width;
      end
    end
  end

  assign adc_enable_a = busy;
  assign adc_enable_b = busy;
  assign adc_enable_c = busy;
  assign adc_enable_d = busy;
  assign adc_valid_a  = busy;
  assign adc_valid_b  = busy;
  assign adc_valid_c  = busy;
  assign adc_valid_d  = busy;
endmodule
